// File: rtl/cic_pkg.sv
// Shared CIC helpers: bit-growth, internal width and output shift, plus the
// interpolator control state type. Also used by the decimator.
package cic_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cic_state_t;

    // Ceiling log2; the ratio is a power of two, so this is exact.
    function automatic int cic_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int cic_bit_growth(input int stages, input int ratio);
        return stages * cic_log2(ratio);
    endfunction

    function automatic int cic_width(input int in_width, input int stages, input int ratio);
        return in_width + cic_bit_growth(stages, ratio);
    endfunction

    function automatic int cic_shift(input int stages, input int ratio);
        return (stages - 1) * cic_log2(ratio);
    endfunction

endpackage

// File: rtl/cic_round_sat.sv
// Half-up rounding arithmetic right shift followed by saturation to a narrower
// signed width. Purely combinational.
module cic_round_sat #(
    parameter int IN_WIDTH  = 41,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT     = 6
) (
    input  logic signed [IN_WIDTH-1:0]  i_data,
    output logic signed [OUT_WIDTH-1:0] o_data
);

    // One guard bit so the rounding offset can never wrap the input.
    localparam int EXT_W = IN_WIDTH + 1;
    localparam int SH_W  = EXT_W - SHIFT;

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_rounded;
    logic signed [SH_W-1:0]  w_scaled;

    assign w_ext = {i_data[IN_WIDTH-1], i_data};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
            assign w_rounded = w_ext + $signed(HALF);
        end else begin : g_no_round
            assign w_rounded = w_ext;
        end
    endgenerate

    assign w_scaled = w_rounded[EXT_W-1:SHIFT];

    generate
        if (SH_W > OUT_WIDTH) begin : g_sat
            // In range only when every bit above the output sign bit matches it.
            logic [SH_W-OUT_WIDTH:0] w_hi;
            assign w_hi   = w_scaled[SH_W-1:OUT_WIDTH-1];
            assign o_data = ((&w_hi) || (~|w_hi)) ? w_scaled[OUT_WIDTH-1:0] :
                            (w_scaled[SH_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                              : {1'b0, {(OUT_WIDTH-1){1'b1}}});
        end else begin : g_ext
            assign o_data = OUT_WIDTH'(w_scaled);
        end
    endgenerate

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: comb chain at the input rate, R integrator
// advances per input with valid/ready flow control on the output.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int INPUT_WIDTH   = 32,
    parameter int OUTPUT_WIDTH  = 32,
    parameter int STAGES        = 3,
    parameter int INTERPOLATION = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [INPUT_WIDTH-1:0]  data_in,
    input  logic                           data_valid,
    output logic                           input_ready,
    output logic signed [OUTPUT_WIDTH-1:0] data_out,
    output logic                           output_valid,
    input  logic                           output_ready
);

    localparam int LOG2R = cic_log2(INTERPOLATION);
    localparam int W     = cic_width(INPUT_WIDTH, STAGES, INTERPOLATION);
    localparam int S     = cic_shift(STAGES, INTERPOLATION);
    localparam logic [LOG2R-1:0] LAST_PHASE = LOG2R'(INTERPOLATION - 1);

    cic_state_t                     r_state;
    logic [LOG2R-1:0]               r_phase;
    logic                           r_out_valid;
    logic signed [OUTPUT_WIDTH-1:0] r_data_out;
    logic signed [W-1:0]            r_comb_out;

    logic                           w_accept;
    logic                           w_advance;
    logic signed [W-1:0]            w_comb  [STAGES+1];
    logic signed [W-1:0]            w_integ [STAGES+1];
    logic signed [OUTPUT_WIDTH-1:0] w_scaled;

    assign input_ready  = (r_state == ST_IDLE);
    assign output_valid = r_out_valid;
    assign data_out     = r_data_out;

    assign w_accept  = data_valid && input_ready;
    assign w_advance = (r_state == ST_RUN) && (!r_out_valid || output_ready);

    assign w_comb[0] = W'(data_in);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_comb
            logic signed [W-1:0] r_dly;
            assign w_comb[gi+1] = w_comb[gi] - r_dly;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dly <= '0;
                end else if (w_accept) begin
                    r_dly <= w_comb[gi];
                end
            end
        end
    endgenerate

    // Zero-stuffing: the comb result enters only on phase 0 of each burst.
    assign w_integ[0] = (r_phase == '0) ? r_comb_out : '0;

    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_integ
            logic signed [W-1:0] r_acc;
            assign w_integ[gi+1] = r_acc + w_integ[gi];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (w_advance) begin
                    r_acc <= w_integ[gi+1];
                end
            end
        end
    endgenerate

    cic_round_sat #(
        .IN_WIDTH  (W),
        .OUT_WIDTH (OUTPUT_WIDTH),
        .SHIFT     (S)
    ) u_round_sat (
        .i_data (w_integ[STAGES]),
        .o_data (w_scaled)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_comb_out  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_phase <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_advance) begin
                        r_phase <= r_phase + LOG2R'(1);
                        if (r_phase == LAST_PHASE) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_accept) begin
                r_comb_out <= w_comb[STAGES];
            end

            if (w_advance) begin
                r_out_valid <= 1'b1;
                r_data_out  <= w_scaled;
            end else if (output_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench: 32-bit and 16-bit output instances share stimulus and are
// compared against an impulse-response convolution model of the CIC.
module tb_cic_interpolator;

    localparam int R    = 8;
    localparam int N    = 3;
    localparam int SH   = 6;
    localparam int HLEN = N * (R - 1) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] data_in;
    logic               data_valid;
    logic               output_ready;
    logic               input_ready, output_valid;
    logic signed [31:0] data_out;
    logic               ir16, ov16;
    logic signed [15:0] do16;

    int n_checks = 0;
    int n_pass   = 0;

    longint xs[$];
    longint obs32[$];
    longint obs16[$];
    int     n32 = 0;
    int     n16 = 0;
    int     h[32];
    logic   stall32 = 1'b0, stall16 = 1'b0;
    longint held32 = 0, held16 = 0;

    always #5 clk = ~clk;

    cic_interpolator #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(32), .STAGES(N), .INTERPOLATION(R)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .input_ready(input_ready), .data_out(data_out), .output_valid(output_valid),
        .output_ready(output_ready)
    );

    cic_interpolator #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(16), .STAGES(N), .INTERPOLATION(R)) dut16 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .input_ready(ir16), .data_out(do16), .output_valid(ov16),
        .output_ready(output_ready)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Impulse response of N cascaded length-R boxcars at the high rate.
    task automatic build_h();
        int t[32];
        for (int i = 0; i < 32; i++) h[i] = (i < R) ? 1 : 0;
        for (int st = 1; st < N; st++) begin
            for (int i = 0; i < 32; i++) t[i] = 0;
            for (int i = 0; i < 32; i++)
                for (int j = 0; j < R; j++)
                    if (i + j < 32) t[i+j] += h[i];
            for (int i = 0; i < 32; i++) h[i] = t[i];
        end
    endtask

    function automatic longint full_val(int n);
        longint acc = 0;
        for (int k = 0; k < xs.size(); k++) begin
            int d = n - k * R;
            if (d >= 0 && d < HLEN) acc += xs[k] * longint'(h[d]);
        end
        return acc;
    endfunction

    function automatic longint expect_out(int n, int width);
        longint v, mx, mn;
        v  = (full_val(n) + (longint'(1) <<< (SH - 1))) >>> SH;
        mx = (longint'(1) <<< (width - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) v = mx;
        if (v < mn) v = mn;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            xs.delete(); obs32.delete(); obs16.delete();
            n32 = 0; n16 = 0; stall32 = 1'b0; stall16 = 1'b0;
        end else begin
            if (stall32 && output_valid) check("hold32", longint'(data_out), held32);
            if (stall16 && ov16) check("hold16", longint'(do16), held16);
            stall32 = output_valid && !output_ready;
            stall16 = ov16 && !output_ready;
            held32  = longint'(data_out);
            held16  = longint'(do16);
            if (data_valid && input_ready) xs.push_back(longint'(data_in));
            if (output_valid && output_ready) begin
                check($sformatf("model32[%0d]", n32), longint'(data_out), expect_out(n32, 32));
                obs32.push_back(longint'(data_out));
                n32++;
            end
            if (ov16 && output_ready) begin
                check($sformatf("model16[%0d]", n16), longint'(do16), expect_out(n16, 16));
                obs16.push_back(longint'(do16));
                n16++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", longint'(input_ready), 1);
        @(posedge clk); #1;
    endtask

    // Returns 1 time unit after the accepting edge.
    task automatic send_one(input logic signed [31:0] v);
        int t = 0;
        data_in    = v;
        data_valid = 1'b1;
        while (!input_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_wait", longint'(t < 100), 1);
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int t = 0;
        while ((obs32.size() < n || obs16.size() < n) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        check("obs_count", longint'(obs32.size() >= n && obs16.size() >= n), 1);
    endtask

    task automatic run_impulse(input string tag);
        int lit[8] = '{1, 3, 6, 10, 15, 21, 28, 36};
        send_one(32'sd64);
        @(negedge clk);
        check({tag, "_valid_early"}, longint'(output_valid), 0);
        @(negedge clk);
        check({tag, "_valid_lat"}, longint'(output_valid), 1);
        check({tag, "_first"}, longint'(data_out), 1);
        repeat (3) send_one(32'sd0);
        wait_obs(32);
        for (int i = 0; i < 8 && i < obs32.size() && i < obs16.size(); i++) begin
            check($sformatf("%s32[%0d]", tag, i), obs32[i], longint'(lit[i]));
            check($sformatf("%s16[%0d]", tag, i), obs16[i], longint'(lit[i]));
        end
    endtask

    task automatic run_dc(input logic signed [31:0] v, input int n_in,
                          input longint exp32, input longint exp16, input string tag);
        do_reset();
        repeat (n_in) send_one(v);
        wait_obs(n_in * R);
        for (int i = 3 * R; i < n_in * R && i < obs32.size() && i < obs16.size(); i++) begin
            check($sformatf("%s32[%0d]", tag, i), obs32[i], exp32);
            check($sformatf("%s16[%0d]", tag, i), obs16[i], exp16);
        end
    endtask

    initial begin
        int lit[8] = '{1, 3, 6, 10, 15, 21, 28, 36};
        int hsum, last, acc_cnt;
        rst = 1'b1; data_valid = 1'b0; data_in = '0; output_ready = 1'b1;

        build_h();
        hsum = 0;
        for (int i = 0; i < 32; i++) hsum += h[i];
        for (int i = 0; i < 8; i++) check($sformatf("h[%0d]", i), longint'(h[i]), longint'(lit[i]));
        check("h_sum", longint'(hsum), 512);
        check("h_tail", longint'(h[HLEN-1]), 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", longint'(output_valid), 0);
        check("rst_data", longint'(data_out), 0);
        check("rst_valid16", longint'(ov16), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", longint'(input_ready), 1);
        @(posedge clk); #1;

        run_impulse("imp");

        run_dc(32'sd1000, 6, 1000, 1000, "dc");
        run_dc(32'sd40000, 5, 40000, 32767, "satp");
        run_dc(-32'sd40000, 5, -40000, -32768, "satn");

        // Stall for 5 cycles with phase 3 next.
        do_reset();
        send_one($urandom);
        repeat (3) begin @(posedge clk); #1; end
        output_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        output_ready = 1'b1;
        repeat (4) send_one($urandom);
        wait_obs(40);
        check("bp_count", longint'(n32), 40);

        // Reset while phase is 4.
        do_reset();
        send_one(32'sd64);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", longint'(output_valid), 0);
        check("midrst_data", longint'(data_out), 0);
        check("midrst_valid16", longint'(ov16), 0);
        check("midrst_ready", longint'(input_ready), 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", longint'(input_ready), 1);
        @(posedge clk); #1;
        run_impulse("rerun");

        // data_valid held high: one accept every R+1 cycles.
        do_reset();
        data_valid = 1'b1;
        last = -1;
        acc_cnt = 0;
        for (int c = 0; c < 63; c++) begin
            data_in = $urandom;
            @(negedge clk);
            if (input_ready) begin
                if (last >= 0) check("accept_period", longint'(c - last), R + 1);
                last = c;
                acc_cnt++;
            end
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        check("accept_count", longint'(acc_cnt), 7);

        // Randomized traffic with random backpressure.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            data_valid   = ($urandom % 2) == 0;
            data_in      = $urandom;
            output_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        data_valid   = 1'b0;
        output_ready = 1'b1;
        repeat (30) begin @(posedge clk); #1; end
        check("rand_out32", longint'(n32), longint'(R * xs.size()));
        check("rand_out16", longint'(n16), longint'(R * xs.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, 32, signed input sample width.
REQ-002 SHALL have parameter OUTPUT_WIDTH, 32, signed output sample width.
REQ-003 SHALL have parameter STAGES, 3, number of comb and integrator stages (N), 1..6.
REQ-004 SHALL have parameter INTERPOLATION, 8, upsample ratio R, a power of two, 2..64.
REQ-005 SHALL have port clk  input  1  processing clock, single clock domain, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port data_in  input  INPUT_WIDTH  signed two's-complement low-rate sample.
REQ-008 SHALL have port data_valid  input  1  data_in valid.
REQ-009 SHALL have port input_ready  output  1  block accepts data_in this cycle.
REQ-010 SHALL have port data_out  output  OUTPUT_WIDTH  signed interpolated sample.
REQ-011 SHALL have port output_valid  output  1  data_out valid.
REQ-012 SHALL have port output_ready  input  1  downstream accepts data_out.

Function
REQ-013 SHALL treat an input as accepted on a rising edge where data_valid and input_ready are both 1.
REQ-014 SHALL use internal width W = INPUT_WIDTH + STAGES*log2(R) with signed wrap-around (modular) arithmetic in all stages, with comb delay M=1.
REQ-015 SHALL run the comb chain once per accepted input; each stage computes y = x - x_prev, with the result registered on the accept edge.
REQ-016 SHALL have two FSM states, IDLE and RUN; input_ready = 1 only in IDLE; an accept moves IDLE->RUN with phase counter 0.
REQ-017 SHALL, in RUN, advance once per cycle when output_valid=0 or output_ready=1. An advance does the following.
- Updates all integrators in cascade order.
- Feeds the first integrator with the comb output at phase 0 and with 0 at phases 1..R-1.
- Increments phase.
REQ-018 SHALL return RUN->IDLE on the advance with phase = R-1, giving a sustained throughput of one input per R+1 cycles.
REQ-019 SHALL load the output register on each advance with round(last integrator >> S), where S = (STAGES-1)*log2(R).
- Rounding is half-up: add 1<<(S-1) before the arithmetic shift; no rounding applies when S = 0.
REQ-020 SHALL saturate the scaled value to OUTPUT_WIDTH: positive overflow gives 0x7F..F and negative overflow gives 0x80..0.
REQ-021 SHALL set output_valid on each advance and clear it on an output_ready=1 edge with no new advance; data_out SHALL stay stable while output_valid=1 and output_ready=0.
REQ-022 SHALL produce the first output of a burst at latency 2 clk after the accept edge (comb register, then integrator plus output register).
REQ-023 SHALL freeze integrators, phase and comb state while stalled; no sample is lost or duplicated.
REQ-024 SHALL ignore data_valid while in RUN and SHALL NOT buffer that input.

Reset
REQ-025 SHALL, on rst=1 and asynchronously, clear all comb registers, comb delays, integrators, phase and the output register to 0, and set FSM=IDLE and output_valid=0.
REQ-026 SHALL discard an in-progress burst on reset mid-operation; input_ready SHALL be 1 on the first edge after rst deasserts.

Structure
REQ-027 SHALL take bit-growth, W and S calculation functions from shared package cic_pkg, which the decimator also uses.
REQ-028 SHALL implement rounding and saturation in sub-module cic_round_sat (IN_WIDTH, OUT_WIDTH, SHIFT), shared with the decimator.
REQ-029 SHALL generate comb and integrator stages with generate loops; no multipliers.

Verification (STAGES=3, R=8, S=6, INPUT_WIDTH=32 unless stated)
REQ-030 SHALL test impulse: data_in=64, then 0s, with output_ready=1 -> first eight outputs are 1,3,6,10,15,21,28,36 and the first arrives 2 clk after accept.
REQ-031 SHALL test DC: a continuous stream of 1000 -> every output equals 1000 after 3 input periods (24 outputs).
REQ-032 SHALL test saturation with OUTPUT_WIDTH=16: DC 40000 -> 32767 after settling; DC -40000 -> -32768.
REQ-033 SHALL test backpressure: output_ready=0 for 5 cycles at phase 3 -> data_out held constant and the full sequence identical to the unstalled reference model.
REQ-034 SHALL test reset during phase 4 -> output_valid=0 immediately, all state 0, then impulse rerun reproduces REQ-030 exactly.
REQ-035 SHALL test data_valid held high continuously -> exactly one input accepted per 9 cycles and input_ready low throughout RUN.
